// File: rtl/alu_pkg.sv
// Shared definitions for the Solix-16 ALU: opcode encoding, flag bit positions
// and the default datapath width.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_op_e;

    // Bit positions inside the packed {Z,N,C,V} status word
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_flags_reg.sv
// Status-flag register: asynchronous active-high clear, captures new flags
// only when the write enable is high.
module alu_flags_reg (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_i,
    input  logic [3:0] flags_i,
    output logic [3:0] flags_o
);

    logic [3:0] flags_d;
    logic [3:0] flags_q;

    always_comb begin
        flags_d = flags_q;
        if (we_i) begin
            flags_d = flags_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/alu.sv
// Solix-16 integer ALU: combinational result and Z/N/C/V flags, plus a clocked
// status register that snapshots the flags for later conditional branches.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_op,
    input  logic             flag_we,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic [3:0]       flags_q
);

    alu_op_e        op;
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;
    logic [3:0]     flags_now;

    assign op = alu_op_e'(alu_op);

    // Extra top bit is the carry-out for ADD and the borrow for SUB
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sum_ext[WIDTH-1:0];
                carry    = sum_ext[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                           (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = diff_ext[WIDTH-1:0];
                carry    = ~diff_ext[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                           (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~a;
            ALU_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            ALU_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            default: begin
                result   = '0;
                carry    = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

    assign zero     = (result == '0);
    assign negative = result[WIDTH-1];

    always_comb begin
        flags_now         = '0;
        flags_now[FLAG_Z] = zero;
        flags_now[FLAG_N] = negative;
        flags_now[FLAG_C] = carry;
        flags_now[FLAG_V] = overflow;
    end

    alu_flags_reg u_flags_reg (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (flag_we),
        .flags_i (flags_now),
        .flags_o (flags_q)
    );

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the Solix-16 ALU: directed corner vectors, then
// randomized operations checked against an integer-arithmetic reference model.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [2:0]  alu_op = '0;
    logic        flag_we = 1'b0;
    logic [15:0] result;
    logic        zero, negative, carry, overflow;
    logic [3:0]  flags_q;

    int unsigned total = 0;
    int unsigned bad   = 0;

    alu #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .alu_op   (alu_op),
        .flag_we  (flag_we),
        .result   (result),
        .zero     (zero),
        .negative (negative),
        .carry    (carry),
        .overflow (overflow),
        .flags_q  (flags_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned/signed interpretations
    function automatic void ref_alu(input int op, input int ua, input int ub,
                                    output logic [15:0] res, output logic [3:0] fl);
        int sa, sb, sr, r;
        logic c, v;
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        c = 1'b0;
        v = 1'b0;
        case (op)
            0: begin r = (ua + ub) % 65536; c = (ua + ub) > 65535;
                     sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            1: begin r = (ua - ub + 65536) % 65536; c = (ua >= ub);
                     sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: r = 65535 - ua;
            6: begin r = (ua * 2) % 65536; c = (ua >= 32768); end
            default: begin r = ua / 2; c = (ua % 2) == 1; end
        endcase
        res = 16'(r);
        fl  = {r == 0, r >= 32768, c, v};
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  fl;
    } vec_t;

    vec_t dir [16] = '{
        '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101},
        '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010},
        '{3'd0, 16'h8000, 16'hFFFF, 16'h7FFF, 4'b0011},
        '{3'd1, 16'd25,   16'd10,   16'd15,   4'b0010},
        '{3'd1, 16'd42,   16'd42,   16'h0000, 4'b1010},
        '{3'd1, 16'd10,   16'd20,   16'hFFF6, 4'b0100},
        '{3'd1, 16'h7FFF, 16'hFFFF, 16'h8000, 4'b0101},
        '{3'd2, 16'hAAAA, 16'h5555, 16'h0000, 4'b1000},
        '{3'd2, 16'hABCD, 16'h00FF, 16'h00CD, 4'b0000},
        '{3'd3, 16'hAAAA, 16'h5555, 16'hFFFF, 4'b0100},
        '{3'd4, 16'h1234, 16'h1234, 16'h0000, 4'b1000},
        '{3'd5, 16'hFFFF, 16'h1234, 16'h0000, 4'b1000},
        '{3'd6, 16'h8000, 16'h5A5A, 16'h0000, 4'b1010},
        '{3'd6, 16'h00FF, 16'h0000, 16'h01FE, 4'b0000},
        '{3'd7, 16'h0001, 16'hFFFF, 16'h0000, 4'b1010},
        '{3'd7, 16'hFF00, 16'h0000, 16'h7F80, 4'b0000}
    };

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    logic [15:0] exp_res;
    logic [3:0]  exp_fl;
    logic [3:0]  exp_reg;

    initial begin
        // Register held in reset while combinational paths are exercised
        #2;
        check("reset_flags_q", 32'(flags_q), 32'h0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            alu_op = dir[i].op; a = dir[i].a; b = dir[i].b; flag_we = 1'b1;
            #1;
            check($sformatf("dir%0d_result", i), 32'(result), 32'(dir[i].res));
            check($sformatf("dir%0d_flags", i), 32'({zero, negative, carry, overflow}), 32'(dir[i].fl));
        end
        @(posedge clk); #1;
        check("rst_dominates_we", 32'(flags_q), 32'h0);

        // Capture, hold, and asynchronous clear
        @(negedge clk);
        rst = 1'b0; alu_op = 3'd0; a = 16'hFFFF; b = 16'h0001; flag_we = 1'b1;
        @(posedge clk); #1;
        check("capture_add", 32'(flags_q), 32'hA);
        @(negedge clk);
        flag_we = 1'b0; a = 16'h7FFF; b = 16'h0001;
        @(posedge clk); #1;
        check("hold_we0", 32'(flags_q), 32'hA);
        #2 rst = 1'b1;
        #1;
        check("async_clear", 32'(flags_q), 32'h0);

        // Reset held across edges with write enable asserted
        flag_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst_hold%0d", i), 32'(flags_q), 32'h0);
            check($sformatf("rst_comb%0d", i), 32'({result, zero, negative, carry, overflow}),
                  32'({16'h8000, 4'b0101}));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_no_edge", 32'(flags_q), 32'h0);
        @(posedge clk); #1;
        check("release_capture", 32'(flags_q), 32'h5);

        // Randomized operations with random flag writes
        exp_reg = 4'h5;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            alu_op  = 3'($urandom_range(0, 7));
            a       = pick_operand();
            b       = pick_operand();
            flag_we = 1'($urandom_range(0, 1));
            #1;
            ref_alu(int'(alu_op), int'(a), int'(b), exp_res, exp_fl);
            check($sformatf("rnd%0d_op%0d_result", i, alu_op), 32'(result), 32'(exp_res));
            check($sformatf("rnd%0d_op%0d_flags", i, alu_op),
                  32'({zero, negative, carry, overflow}), 32'(exp_fl));
            if (flag_we) exp_reg = exp_fl;
            @(posedge clk); #1;
            check($sformatf("rnd%0d_flags_q", i), 32'(flags_q), 32'(exp_reg));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
